display_scan_ctrl: RTL
======================

# display_scan_ctrl

Sequencer that drives the shared BCD-to-7-segment mux and serializes the six digits of the clock display into an external chain of 8-bit shift registers (595-style). Sits between the time register / mux and the chip pins: it steps `segment_select` through all digits, captures each 7-segment pattern plus a decimal-point bit, shifts the 48 bits out MSB-first, then pulses the storage latch so the display updates atomically.

## Interface
Parameters:
- `NUM_DIGITS`, 6: digits per frame; legal range 1–7. Select codes 0..NUM_DIGITS-1 address digits.
- `HALF_CYCLES`, 1: system clocks per serial-clock half period and latch pulse width; ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  enable; low aborts any frame and holds IDLE.
- `start`  in  1  frame request; sampled only in IDLE.
- `dp_mask`  in  NUM_DIGITS  decimal-point bit per digit (bit i → digit i).
- `led_in`  in  7  segment pattern returned by the mux for the current select.
- `segment_select`  out  3  digit select to the mux; 3'h7 when not scanning (mux blanks).
- `sr_data`  out  1  serial data to shift-register chain.
- `sr_clk`  out  1  shift clock; data shifts on its rising edge.
- `sr_latch`  out  1  storage-register latch pulse.
- `busy`  out  1  high from LOAD through LATCH inclusive.
- `frame_done`  out  1  one-cycle pulse after a completed latch.

## Operation
- All outputs registered. Reset value of every output: `segment_select`=3'h7, `sr_data`=0, `sr_clk`=0, `sr_latch`=0, `busy`=0, `frame_done`=0.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: `segment_select`=7, `sr_clk`=0, `sr_latch`=0. If `en` && `start` → LOAD with digit counter = NUM_DIGITS-1.
- LOAD (1 cycle): `segment_select`=digit; at end of cycle capture byte = {`dp_mask`[digit], `led_in`[6:0]}, bit counter = 7 → SHIFT_LO. `led_in` is taken combinationally from the mux and must be valid in the LOAD cycle.
- SHIFT_LO (HALF_CYCLES cycles): `sr_clk`=0, `sr_data`=byte[7] → SHIFT_HI.
- SHIFT_HI (HALF_CYCLES cycles): `sr_clk`=1, `sr_data` held. On exit: byte <<= 1; if bit>0, bit-- → SHIFT_LO; else if digit>0, digit-- → LOAD; else → LATCH.
- LATCH (HALF_CYCLES cycles): `sr_clk`=0, `sr_data`=0, `sr_latch`=1; then → IDLE with `frame_done`=1 for one cycle.
- Order: digit NUM_DIGITS-1 (hours MSD) first, digit 0 (seconds LSD) last; within a digit dp first, then led[6]..led[0]. The last bit shifted therefore sits nearest the chain input.
- `start` while busy: ignored, not queued. `start` held high: back-to-back frames, one IDLE cycle between them.
- `en` low in any non-IDLE state: next cycle IDLE, all outputs to reset values, no latch, no `frame_done`. `reset` mid-frame: same.

## Timing
- IDLE cycle sampling `start` = t; `busy` rises and LOAD entered at t+1.
- Per digit: 1 + 16·HALF_CYCLES cycles. Frame (busy high): NUM_DIGITS·(1+16·HALF_CYCLES)+HALF_CYCLES cycles; default 103.
- `frame_done` in the first IDLE cycle after LATCH; `busy` low in that cycle.
- `sr_data` stable for the full high phase and HALF_CYCLES cycles before each `sr_clk` rise; `sr_latch` never overlaps `sr_clk` high.

## Test plan
- Reset then idle: all outputs at reset values, `segment_select`=7; `start` with `en`=0 → no activity for 200 cycles.
- Default params, digits 5..0 = 1,2,3,4,5,6 via mux model, `dp_mask`=6'b010100: sample `sr_data` on 48 `sr_clk` rises → dp bits set for digits 4 and 2, patterns match bcd-to-7seg codes in order 1..6; one `sr_latch` pulse of 1 cycle; `frame_done` at cycle t+104.
- HALF_CYCLES=3: `sr_clk` high/low phases exactly 3 cycles, latch 3 cycles, frame 6·49+3=297 cycles.
- `start` pulsed during cycle 40 of a frame → ignored, exactly one frame/latch; `start` held high → frames separated by one IDLE cycle.
- `en` dropped at bit 20 → next cycle all outputs reset values, no latch or `frame_done`; re-enable + `start` → full correct frame.
- `reset` asserted mid-SHIFT_HI → next cycle reset values; NUM_DIGITS=4 run → 32 bits, selects 3..0 only.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: control, mux and shift-register chain signals of the display scanner
interface display_scan_ctrl_if #(parameter int NUM_DIGITS = 6);
  logic en;
  logic start;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [6:0] led_in;
  logic [2:0] segment_select;
  logic sr_data;
  logic sr_clk;
  logic sr_latch;
  logic busy;
  logic frame_done;
  modport master(output en, start, dp_mask, led_in, input segment_select, sr_data, sr_clk, sr_latch, busy, frame_done);
  modport slave(input en, start, dp_mask, led_in, output segment_select, sr_data, sr_clk, sr_latch, busy, frame_done);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: scans digits through the 7-seg mux and serializes them into a 595 chain
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int HALF_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  display_scan_ctrl_if.slave bus
);
  localparam int HW = HALF_CYCLES > 1 ? $clog2(HALF_CYCLES) : 1;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t state, nxt;
  logic [HW-1:0] hc;
  logic [2:0] digit, digit_nxt, bit_cnt, bit_nxt;
  logic [7:0] sreg, sreg_nxt, dp_ext;
  logic hc_last;
  assign hc_last = hc == HW'(HALF_CYCLES - 1);
  assign dp_ext = 8'(bus.dp_mask);
  always_comb begin
    nxt = state;
    digit_nxt = digit;
    bit_nxt = bit_cnt;
    sreg_nxt = sreg;
    case (state)
      IDLE: begin
        nxt = bus.start ? LOAD : IDLE;
        digit_nxt = LAST;
      end
      LOAD: begin
        nxt = SHIFT_LO;
        sreg_nxt = {dp_ext[digit], bus.led_in};
        bit_nxt = 3'd7;
      end
      SHIFT_LO: nxt = hc_last ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: if (hc_last) begin
        sreg_nxt = sreg << 1;
        bit_nxt = bit_cnt - 3'd1;
        digit_nxt = bit_cnt == 3'd0 ? digit - 3'd1 : digit;
        nxt = bit_cnt != 3'd0 ? SHIFT_LO : digit != 3'd0 ? LOAD : LATCH;
      end
      LATCH: nxt = hc_last ? IDLE : LATCH;
      default: nxt = IDLE;
    endcase
    if (!bus.en) nxt = IDLE;
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hc <= '0;
      digit <= '0;
      bit_cnt <= '0;
      sreg <= '0;
      bus.segment_select <= 3'h7;
      bus.sr_data <= 1'b0;
      bus.sr_clk <= 1'b0;
      bus.sr_latch <= 1'b0;
      bus.busy <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= nxt;
      hc <= nxt != state ? '0 : hc + 1'b1;
      digit <= digit_nxt;
      bit_cnt <= bit_nxt;
      sreg <= sreg_nxt;
      bus.segment_select <= nxt == LOAD ? digit_nxt : 3'h7;
      bus.sr_data <= (nxt == SHIFT_LO || nxt == SHIFT_HI) && sreg_nxt[7];
      bus.sr_clk <= nxt == SHIFT_HI;
      bus.sr_latch <= nxt == LATCH;
      bus.busy <= nxt != IDLE;
      bus.frame_done <= state == LATCH && nxt == IDLE && bus.en;
    end
  end
endmodule
